switch_capture: RTL and testbench

- Upstream input conditioner for decoder_38.
- Synchronises and debounces the three raw slide switches and one push button.
- On each debounced button press, captures the switch code into a held register and drives the decoder's switch[2:0] and enable[2:0].
- Enable stays off (decoder idle) until the first capture.

---
 rtl/switch_capture_pkg.sv | 13 +
 rtl/switch_capture_debounce_bit.sv | 44 ++++
 rtl/switch_capture.sv | 77 +++++++
 tb/tb_switch_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_capture_pkg.sv
// Shared types and constants for the switch/button input conditioner.
package switch_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam int unsigned DEB_W         = 16;
  localparam logic [2:0]  ENABLE_ON_DEF = 3'b100;

endpackage

// File: rtl/switch_capture_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a consecutive-cycle debouncer.
module debounce_bit
  import switch_capture_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronised level disagrees with deb.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == DEB_CYCLES - 1'b1) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/switch_capture.sv
// Debounces three slide switches and a push button; each accepted press latches
// the switch code and arms the decoder enable.
module switch_capture
  import switch_capture_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50000,
  parameter logic [2:0]       ENABLE_ON  = ENABLE_ON_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_raw,
  input  logic       btn_raw,
  output logic [2:0] switch,
  output logic [2:0] enable,
  output logic       update,
  output logic [3:0] press_cnt
);

  logic [2:0] sw_deb;
  logic       btn_deb;

  for (genvar i = 0; i < 3; i++) begin : g_sw
    debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw_raw[i]),
      .dout (sw_deb[i])
    );
  end

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_raw),
    .dout (btn_deb)
  );

  state_e     state_q;
  logic [2:0] switch_q;
  logic [2:0] enable_q;
  logic       update_q;
  logic [3:0] press_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      switch_q    <= '0;
      enable_q    <= '0;
      update_q    <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_deb) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          switch_q    <= sw_deb;
          enable_q    <= ENABLE_ON;
          press_cnt_q <= press_cnt_q + 4'd1;
          update_q    <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!btn_deb) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign switch    = switch_q;
  assign enable    = enable_q;
  assign update    = update_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_switch_capture.sv
// Self-checking bench for switch_capture with DEB_CYCLES=4 and a behavioural model.
module tb_switch_capture;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_raw = 3'b000;
  logic       btn_raw = 1'b0;
  logic [2:0] switch, enable;
  logic       update;
  logic [3:0] press_cnt;

  int total = 0;
  int bad   = 0;

  switch_capture #(.DEB_CYCLES(16'd4), .ENABLE_ON(3'b100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .btn_raw  (btn_raw),
    .switch   (switch),
    .enable   (enable),
    .update   (update),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw levels delayed two edges, a level is accepted once it
  // has disagreed with the accepted value for DEB consecutive edges; a press is
  // accepted when the button level goes high from a released state.
  logic [3:0] m_s1, m_s2, m_deb;
  int         m_run [4];
  bit         m_ready, m_pending;
  logic [2:0] m_switch, m_enable;
  logic       m_update;
  logic [3:0] m_cnt;

  int cyc = 0;
  int dut_upd = 0, mod_upd = 0;
  int dut_upd_cyc = -1, mod_upd_cyc = -1;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_ready = 1'b1; m_pending = 1'b0;
    m_switch = '0; m_enable = '0; m_update = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic [3:0] raw;
    logic [3:0] old_deb;
    raw = {btn_raw, sw_raw};
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_deb  = m_deb;
    m_update = 1'b0;
    if (m_pending) begin
      m_switch  = old_deb[2:0];
      m_enable  = 3'b100;
      m_cnt     = m_cnt + 4'd1;
      m_update  = 1'b1;
      m_pending = 1'b0;
    end else if (m_ready && old_deb[3]) begin
      m_pending = 1'b1;
      m_ready   = 1'b0;
    end else if (!old_deb[3]) begin
      m_ready = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (update === 1'b1) begin dut_upd++; dut_upd_cyc = cyc; end
    if (m_update) begin mod_upd++; mod_upd_cyc = cyc; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int hi, input int lo);
    btn_raw = 1'b1; ticks(hi);
    btn_raw = 1'b0; ticks(lo);
  endtask

  function automatic logic [7:0] led_of(input logic [2:0] s, input logic [2:0] e);
    logic [7:0] one;
    one = 8'd1;
    if (e != 3'b100) return 8'hff;
    return ~(one << s);
  endfunction

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    ticks(3);
    total++;
    if ({switch, enable, update, press_cnt} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {switch, enable, update, press_cnt});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_no_press();
    int u0;
    u0 = dut_upd;
    sw_raw = 3'b010; btn_raw = 1'b0;
    ticks(50);
    total++;
    if (switch !== 3'b000 || enable !== 3'b000 || press_cnt !== 4'h0) begin
      bad++; $display("FAIL idle_hold: got sw=%b en=%b cnt=%h want 000/000/0", switch, enable, press_cnt);
    end
    total++;
    if (dut_upd != u0) begin
      bad++; $display("FAIL idle_update: got %0d pulses want 0", dut_upd - u0);
    end
  endtask

  task automatic test_first_press();
    int u0, start;
    u0 = dut_upd; start = cyc;
    btn_raw = 1'b1;
    ticks(20);
    total++;
    if (dut_upd - u0 != 1 || dut_upd_cyc != mod_upd_cyc) begin
      bad++; $display("FAIL first_press_timing: got %0d pulses at +%0d want 1 at +%0d",
                      dut_upd - u0, dut_upd_cyc - start, mod_upd_cyc - start);
    end
    total++;
    if (switch !== 3'b010 || enable !== 3'b100 || press_cnt !== 4'h1) begin
      bad++; $display("FAIL first_press_vals: got sw=%b en=%b cnt=%h want 010/100/1", switch, enable, press_cnt);
    end
    total++;
    if (led_of(switch, enable) !== 8'b11111011) begin
      bad++; $display("FAIL first_press_led: got %b want 11111011", led_of(switch, enable));
    end
  endtask

  task automatic test_hold_change();
    int u0;
    u0 = dut_upd;
    sw_raw = 3'b111;
    ticks(15);
    total++;
    if (switch !== 3'b010 || dut_upd != u0) begin
      bad++; $display("FAIL held_ignore: got sw=%b pulses=%0d want 010/0", switch, dut_upd - u0);
    end
    btn_raw = 1'b0; ticks(10);
    btn_raw = 1'b1; ticks(15);
    total++;
    if (switch !== 3'b111 || press_cnt !== 4'h2 || dut_upd - u0 != 1) begin
      bad++; $display("FAIL second_press: got sw=%b cnt=%h pulses=%0d want 111/2/1", switch, press_cnt, dut_upd - u0);
    end
    total++;
    if (led_of(switch, enable) !== 8'b01111111) begin
      bad++; $display("FAIL second_press_led: got %b want 01111111", led_of(switch, enable));
    end
    btn_raw = 1'b0; ticks(10);
  endtask

  task automatic test_glitch();
    int u0;
    logic [3:0] c0;
    u0 = dut_upd; c0 = press_cnt;
    for (int w = 1; w <= 3; w++) press(w, 5);
    total++;
    if (dut_upd != u0 || press_cnt !== c0) begin
      bad++; $display("FAIL glitch_reject: got pulses=%0d cnt=%h want 0/%h", dut_upd - u0, press_cnt, c0);
    end
  endtask

  task automatic test_wrap();
    int u0;
    u0 = dut_upd;
    for (int p = 0; p < 16; p++) press(10, 10);
    total++;
    if (dut_upd - u0 != 16) begin
      bad++; $display("FAIL wrap_pulses: got %0d want 16", dut_upd - u0);
    end
    total++;
    if (press_cnt !== 4'h2 || press_cnt !== m_cnt) begin
      bad++; $display("FAIL wrap_count: got %h want 2 (model %h)", press_cnt, m_cnt);
    end
  endtask

  task automatic test_reset_in_hold();
    int u0;
    sw_raw = 3'b100; ticks(10);
    btn_raw = 1'b1; ticks(12);
    total++;
    if (switch !== 3'b100) begin
      bad++; $display("FAIL pre_reset_sw: got %b want 100", switch);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (switch !== 3'b000 || enable !== 3'b000 || press_cnt !== 4'h0 || update !== 1'b0) begin
      bad++; $display("FAIL async_reset: got sw=%b en=%b cnt=%h upd=%b want all 0", switch, enable, press_cnt, update);
    end
    tick();
    #2 rst_n = 1'b1;
    u0 = dut_upd;
    ticks(20);
    total++;
    if (dut_upd - u0 != 1 || switch !== 3'b100 || press_cnt !== 4'h1 || enable !== 3'b100) begin
      bad++; $display("FAIL post_reset_capture: got pulses=%0d sw=%b cnt=%h en=%b want 1/100/1/100",
                      dut_upd - u0, switch, press_cnt, enable);
    end
    btn_raw = 1'b0; ticks(10);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int seg = 0; seg < 60; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) sw_raw = 3'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
        tick();
        total++;
        if (switch !== m_switch || enable !== m_enable || update !== m_update || press_cnt !== m_cnt) begin
          bad++; errs++;
          if (errs < 10)
            $display("FAIL random_cyc%0d: got sw=%b en=%b upd=%b cnt=%h want %b/%b/%b/%h",
                     cyc, switch, enable, update, press_cnt, m_switch, m_enable, m_update, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_press();
    test_first_press();
    test_hold_change();
    test_glitch();
    test_wrap();
    test_reset_in_hold();
    test_random();
    total++;
    if (dut_upd != mod_upd) begin
      bad++; $display("FAIL update_total: got %0d want %0d", dut_upd, mod_upd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
